seq_rst_ctrl: RTL and testbench

Reset and clock-enable sequencer for the divided-clock test datapath. It synchronizes the board reset and generates a programmable clock-enable `ce` that replaces free-running divided clocks. It releases two downstream reset domains (`rst_a` for the input/state registers, `rst_b` for the output registers) in a fixed order. It also supports a software-requested re-reset using a request/acknowledge handshake.

---
 rtl/seq_rst_ctrl.sv | 122 ++++++++++++
 tb/tb_seq_rst_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/seq_rst_ctrl.sv
// seq_rst_ctrl: board reset synchronizer, clock-enable divider and ordered two-domain reset sequencer
//
// Ports:
//   clki        system clock
//   rsti        asynchronous active-high reset
//   div_sel     ce period minus 1 (0 = ce every cycle)
//   sw_rst_req  software re-reset request, level, held until sw_rst_ack
//   ce          one-cycle clock-enable pulse every div_sel+1 cycles
//   rst_a       domain A (input/state registers) reset, active-high
//   rst_b       domain B (output registers) reset, active-high
//   ready       both domains out of reset, sequencer in RUN
//   sw_rst_ack  one-cycle pulse when a software re-reset completes
//   state       current FSM state (debug)
module seq_rst_ctrl #(
    parameter int STRETCH = 8,
    parameter int DIV_W   = 4
) (
    input  logic             clki,
    input  logic             rsti,
    input  logic [DIV_W-1:0] div_sel,
    input  logic             sw_rst_req,
    output logic             ce,
    output logic             rst_a,
    output logic             rst_b,
    output logic             ready,
    output logic             sw_rst_ack,
    output logic [2:0]       state
);
    localparam int HW = STRETCH > 1 ? $clog2(STRETCH) : 1;

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        REL_A   = 3'd1,
        REL_B   = 3'd2,
        RUN     = 3'd3,
        QUIESCE = 3'd4,
        DRAIN_B = 3'd5
    } state_t;

    state_t           st, nxt;
    logic [1:0]       sync;
    logic             rst_s;
    logic [DIV_W-1:0] cnt, div_sel_q;
    logic             hit;
    logic [HW-1:0]    hold_cnt;
    logic             rel_cnt;
    logic             arm;
    logic             swr;
    logic             trig;
    logic             done;

    always_ff @(posedge clki or posedge rsti)
        if (rsti) sync <= 2'b11;
        else      sync <= {sync[0], 1'b0};

    assign rst_s = sync[1];

    // hit marks the edge that raises ce; the FSM advances on these edges
    assign hit = !rst_s && cnt == div_sel_q;

    // The divide select is only sampled at period boundaries so a change never truncates a period
    always_ff @(posedge clki or posedge rsti)
        if (rsti) begin
            cnt       <= '0;
            div_sel_q <= '0;
            ce        <= 1'b0;
        end else if (rst_s) begin
            cnt       <= '0;
            div_sel_q <= div_sel;
            ce        <= 1'b0;
        end else begin
            cnt       <= hit ? '0 : cnt + 1'b1;
            div_sel_q <= hit ? div_sel : div_sel_q;
            ce        <= hit;
        end

    // A request re-arms only after it has been seen low, so a held request cannot loop
    assign trig = st == RUN && sw_rst_req && arm;
    assign done = st == REL_B && nxt == RUN;

    always_comb begin
        nxt = st;
        case (st)
            HOLD:    nxt = (!rst_s && hold_cnt == HW'(STRETCH - 1)) ? REL_A : HOLD;
            REL_A:   nxt = (hit && rel_cnt) ? REL_B : REL_A;
            REL_B:   nxt = hit ? RUN : REL_B;
            RUN:     nxt = trig ? QUIESCE : RUN;
            QUIESCE: nxt = hit ? DRAIN_B : QUIESCE;
            DRAIN_B: nxt = hit ? HOLD : DRAIN_B;
            default: nxt = HOLD;
        endcase
    end

    // Outputs are decoded from the next state so they change on the edge entering a state
    always_ff @(posedge clki or posedge rsti)
        if (rsti) begin
            st         <= HOLD;
            rst_a      <= 1'b1;
            rst_b      <= 1'b1;
            ready      <= 1'b0;
            sw_rst_ack <= 1'b0;
            hold_cnt   <= '0;
            rel_cnt    <= 1'b0;
            arm        <= 1'b0;
            swr        <= 1'b0;
        end else begin
            st         <= nxt;
            rst_a      <= nxt == HOLD;
            rst_b      <= nxt == HOLD || nxt == REL_A || nxt == DRAIN_B;
            ready      <= nxt == RUN;
            sw_rst_ack <= done && swr;
            hold_cnt   <= (rst_s || st != HOLD) ? '0 : hold_cnt + 1'b1;
            rel_cnt    <= st == REL_A ? rel_cnt ^ hit : 1'b0;
            arm        <= !sw_rst_req || (arm && !trig);
            swr        <= trig || (swr && !done);
        end

    assign state = st;

    // Domain A must never be out of reset... rather, A may never be in reset while B runs
    a_before_b: assert property (@(posedge clki) disable iff (rsti) !(rst_a && !rst_b));
endmodule

// File: tb/tb_seq_rst_ctrl.sv
// tb_seq_rst_ctrl: directed bench for seq_rst_ctrl
module tb_seq_rst_ctrl;
    logic       clki = 1'b0;
    logic       rsti = 1'b0;
    logic [3:0] div_sel = 4'd0;
    logic       sw_rst_req = 1'b0;
    logic       ce, rst_a, rst_b, ready, sw_rst_ack;
    logic [2:0] state;
    int         n_run = 0;
    int         n_fail = 0;

    seq_rst_ctrl #(.STRETCH(8), .DIV_W(4)) dut (
        .clki(clki), .rsti(rsti), .div_sel(div_sel), .sw_rst_req(sw_rst_req),
        .ce(ce), .rst_a(rst_a), .rst_b(rst_b), .ready(ready),
        .sw_rst_ack(sw_rst_ack), .state(state)
    );

    always #5 clki = ~clki;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clki);
        #1;
    endtask

    task automatic power_on(input logic [3:0] d);
        rsti = 1'b1;
        div_sel = d;
        repeat (3) @(posedge clki);
        @(negedge clki);
        rsti = 1'b0;
    endtask

    initial begin
        int es;
        #2 rsti = 1'b1;
        #1;
        check("rst ce", ce, 0);
        check("rst rst_a", rst_a, 1);
        check("rst rst_b", rst_b, 1);
        check("rst ready", ready, 0);
        check("rst ack", sw_rst_ack, 0);
        check("rst state", state, 0);

        power_on(4'd0);
        for (int k = 1; k <= 13; k++) begin
            tick;
            es = k < 10 ? 0 : k < 12 ? 1 : k < 13 ? 2 : 3;
            check($sformatf("po0 state k=%0d", k), state, es);
            check($sformatf("po0 rst_a k=%0d", k), rst_a, k < 10);
            check($sformatf("po0 rst_b k=%0d", k), rst_b, k < 12);
            check($sformatf("po0 ready k=%0d", k), ready, k >= 13);
            check($sformatf("po0 ce k=%0d", k), ce, k >= 3);
            check($sformatf("po0 ack k=%0d", k), sw_rst_ack, 0);
        end

        power_on(4'd3);
        for (int k = 1; k <= 23; k++) begin
            tick;
            es = k < 10 ? 0 : k < 18 ? 1 : k < 22 ? 2 : 3;
            check($sformatf("div4 state k=%0d", k), state, es);
            check($sformatf("div4 ce k=%0d", k), ce, k >= 6 && (k - 6) % 4 == 0);
            check($sformatf("div4 ready k=%0d", k), ready, k >= 22);
        end
        div_sel = 4'd1;
        for (int k = 24; k <= 32; k++) begin
            tick;
            check($sformatf("chg ce k=%0d", k), ce, k >= 26 && k % 2 == 0);
            check($sformatf("chg state k=%0d", k), state, 3);
        end

        sw_rst_req = 1'b1;
        for (int k = 33; k <= 60; k++) begin
            tick;
            es = k < 34 ? 4 : k < 36 ? 5 : k < 44 ? 0 : k < 48 ? 1 : k < 50 ? 2 : 3;
            check($sformatf("swr state k=%0d", k), state, es);
            check($sformatf("swr rst_a k=%0d", k), rst_a, es == 0);
            check($sformatf("swr rst_b k=%0d", k), rst_b, es == 0 || es == 1 || es == 5);
            check($sformatf("swr ready k=%0d", k), ready, es == 3);
            check($sformatf("swr ack k=%0d", k), sw_rst_ack, k == 50);
        end
        sw_rst_req = 1'b0;
        repeat (3) tick;
        check("swr idle state", state, 3);
        check("swr idle ack", sw_rst_ack, 0);

        power_on(4'd3);
        for (int k = 1; k <= 18; k++) tick;
        check("mid state", state, 2);
        check("mid ce", ce, 1);
        #2 rsti = 1'b1;
        #1;
        check("async rst_a", rst_a, 1);
        check("async rst_b", rst_b, 1);
        check("async state", state, 0);
        check("async ready", ready, 0);
        check("async ce", ce, 0);

        power_on(4'd3);
        for (int k = 1; k <= 24; k++) begin
            tick;
            sw_rst_req = (k == 4 || k == 11);
            es = k < 10 ? 0 : k < 18 ? 1 : k < 22 ? 2 : 3;
            check($sformatf("ign state k=%0d", k), state, es);
            check($sformatf("ign ack k=%0d", k), sw_rst_ack, 0);
            check($sformatf("ign ready k=%0d", k), ready, k >= 22);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
